fetch_stage: RTL

Instruction-fetch stage of the 32-bit MIPS pipeline. Holds the program counter and drives the byte-addressed, big-endian, combinational-read instruction memory with it. Captures the returned word into the IF/ID pipeline register. Handles stall, branch/jump redirect with squash, and a sticky halt on any fetch outside the populated instruction bytes.

---
 rtl/fetch_stage.sv | 67 ++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch with PC, IF/ID register, stall, redirect squash and sticky halt.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int MEM_BYTES = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_fault
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_n;
  logic [31:0] pc_n, instr_n, pc4_n, pc_plus4;
  logic [32:0] last_byte;
  logic valid_n, legal;
  assign imem_addr = pc;
  assign pc_plus4 = pc + 32'd4;
  assign fetch_fault = state == HALT;
  // widened so a PC near 2^32 cannot wrap into the legal window
  assign last_byte = {1'b0, pc} + 33'd3;
  assign legal = pc[1:0] == 2'b00 && last_byte < 33'(MEM_BYTES);
  always_comb begin
    state_n = state;
    pc_n = pc;
    instr_n = if_id_instr;
    pc4_n = if_id_pc_plus4;
    valid_n = if_id_valid;
    if (state == HALT || redirect || (!stall && !legal)) begin
      instr_n = 32'h0;
      pc4_n = 32'h0;
      valid_n = 1'b0;
    end
    if (state == RUN) begin
      if (redirect) pc_n = redirect_target;
      else if (!stall && !legal) state_n = HALT;
      else if (!stall) begin
        pc_n = pc_plus4;
        instr_n = imem_data;
        pc4_n = pc_plus4;
        valid_n = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc <= RESET_PC;
      if_id_instr <= 32'h0;
      if_id_pc_plus4 <= 32'h0;
      if_id_valid <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      if_id_instr <= instr_n;
      if_id_pc_plus4 <= pc4_n;
      if_id_valid <= valid_n;
    end
  end
endmodule
